// File: rtl/turn_on_pkg.sv
// Shared definitions for the turn-on PWM array: command codes, mode enum and
// the command decoder used by the top level and every brightness group.
package turn_on_pkg;

   localparam logic [3:0] CMD_HOLD  = 4'b1110;
   localparam logic [3:0] CMD_BLANK = 4'b1101;

   typedef enum logic [1:0] {
      MODE_NORMAL = 2'd0,
      MODE_HOLD   = 2'd1,
      MODE_BLANK  = 2'd2
   } mode_e;

   function automatic mode_e decode_mode(input logic [3:0] cmd);
      mode_e mode;
      case (cmd)
         CMD_HOLD:  mode = MODE_HOLD;
         CMD_BLANK: mode = MODE_BLANK;
         default:   mode = MODE_NORMAL;
      endcase
      return mode;
   endfunction

endpackage

// File: rtl/brightness_pwm_group.sv
// One channel group: shadow and active brightness registers plus the
// registered duty comparators driven by the shared PWM counter.
module brightness_pwm_group
   import turn_on_pkg::*;
#(
   parameter int CH_PER_GROUP = 6,
   parameter int BR_W         = 8,
   parameter int GW           = CH_PER_GROUP * BR_W
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [BR_W-1:0]         pwm_cnt_i,
   input  logic                    wrap_i,
   input  logic                    commit_i,
   input  logic                    capture_i,
   input  logic                    en_i,
   input  mode_e                   mode_i,
   input  logic [GW-1:0]           data_i,
   output logic [GW-1:0]           active_o,
   output logic [CH_PER_GROUP-1:0] pwm_o
);

   logic [GW-1:0]           shadow_q, shadow_d;
   logic [GW-1:0]           active_q, active_d;
   logic [CH_PER_GROUP-1:0] pwm_q, pwm_d;

   always_comb begin
      shadow_d = shadow_q;
      active_d = active_q;
      pwm_d    = '0;
      if (capture_i && en_i) begin
         shadow_d = data_i;
      end else begin
         shadow_d = shadow_q;
      end
      // Commit takes the shadow as it stood before any same-edge capture.
      if (wrap_i && commit_i) begin
         active_d = shadow_q;
      end else begin
         active_d = active_q;
      end
      for (int c = 0; c < CH_PER_GROUP; c++) begin
         pwm_d[c] = (active_q[c*BR_W +: BR_W] > pwm_cnt_i) && en_i && (mode_i != MODE_BLANK);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         shadow_q <= '0;
         active_q <= '0;
         pwm_q    <= '0;
      end else begin
         shadow_q <= shadow_d;
         active_q <= active_d;
         pwm_q    <= pwm_d;
      end
   end

   assign active_o = active_q;
   assign pwm_o    = pwm_q;

endmodule

// File: rtl/turn_on_pwm_array.sv
// Multi-group brightness PWM engine: CTS quiet-time qualifier, free-running
// PWM counter, pending/commit bookkeeping and the per-group datapaths.
module turn_on_pwm_array
   import turn_on_pkg::*;
#(
   parameter int N_GROUPS     = 4,
   parameter int CH_PER_GROUP = 6,
   parameter int BR_W         = 8,
   parameter int CTS_DLY      = 15,
   parameter int CNT_W        = 4,
   parameter int GW           = CH_PER_GROUP * BR_W
) (
   input  logic                             sys_clk,
   input  logic                             sys_reset,
   input  logic [3:0]                       cmd,
   input  logic [N_GROUPS*GW-1:0]           data_i,
   input  logic [N_GROUPS-1:0]              group_en,
   input  logic                             cts,
   input  logic                             error_flag,
   output logic [N_GROUPS*GW-1:0]           data_loop_o,
   output logic [N_GROUPS*CH_PER_GROUP-1:0] pwm_o,
   output logic                             update_pending,
   output logic [15:0]                      frame_cnt
);

   localparam logic [BR_W-1:0]  PWM_LAST = {{(BR_W-1){1'b1}}, 1'b0};
   localparam logic [CNT_W-1:0] CTS_LOAD = CNT_W'(CTS_DLY);

   logic [CNT_W-1:0] cts_cnt_q, cts_cnt_d;
   logic             load_strobe_q, load_strobe_d;
   logic [BR_W-1:0]  pwm_cnt_q, pwm_cnt_d;
   logic             pending_q, pending_d;
   logic [15:0]      frame_q, frame_d;
   mode_e            mode_s;
   logic             capture_s;
   logic             wrap_s;
   logic             commit_s;

   always_comb begin
      mode_s    = decode_mode(cmd);
      capture_s = load_strobe_q && (mode_s != MODE_HOLD) && !error_flag;
      wrap_s    = (pwm_cnt_q == PWM_LAST);
      commit_s  = wrap_s && pending_q;

      if (cts) begin
         cts_cnt_d = CTS_LOAD;
      end else if (cts_cnt_q != '0) begin
         cts_cnt_d = cts_cnt_q - CNT_W'(1);
      end else begin
         cts_cnt_d = cts_cnt_q;
      end
      load_strobe_d = (cts_cnt_q == CNT_W'(1));

      if (wrap_s) begin
         pwm_cnt_d = '0;
      end else begin
         pwm_cnt_d = pwm_cnt_q + BR_W'(1);
      end

      // A capture on the wrap edge keeps pending set for the following period.
      if (capture_s) begin
         pending_d = 1'b1;
      end else if (commit_s) begin
         pending_d = 1'b0;
      end else begin
         pending_d = pending_q;
      end

      if (commit_s) begin
         frame_d = frame_q + 16'd1;
      end else begin
         frame_d = frame_q;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_reset) begin
         cts_cnt_q     <= CTS_LOAD;
         load_strobe_q <= 1'b0;
         pwm_cnt_q     <= '0;
         pending_q     <= 1'b0;
         frame_q       <= 16'd0;
      end else begin
         cts_cnt_q     <= cts_cnt_d;
         load_strobe_q <= load_strobe_d;
         pwm_cnt_q     <= pwm_cnt_d;
         pending_q     <= pending_d;
         frame_q       <= frame_d;
      end
   end

   for (genvar g = 0; g < N_GROUPS; g++) begin : g_grp
      brightness_pwm_group #(
         .CH_PER_GROUP (CH_PER_GROUP),
         .BR_W         (BR_W),
         .GW           (GW)
      ) u_grp (
         .clk_i     (sys_clk),
         .rst_i     (sys_reset),
         .pwm_cnt_i (pwm_cnt_q),
         .wrap_i    (wrap_s),
         .commit_i  (pending_q),
         .capture_i (capture_s),
         .en_i      (group_en[g]),
         .mode_i    (mode_s),
         .data_i    (data_i[g*GW +: GW]),
         .active_o  (data_loop_o[g*GW +: GW]),
         .pwm_o     (pwm_o[g*CH_PER_GROUP +: CH_PER_GROUP])
      );
   end

   assign update_pending = pending_q;
   assign frame_cnt      = frame_q;

endmodule

// File: tb/tb_turn_on_pwm_array.sv
// Self-checking bench for turn_on_pwm_array: a per-cycle behavioural model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_turn_on_pwm_array;

   localparam int NG = 4;
   localparam int NC = 6;
   localparam int DW = NG * NC * 8;
   localparam int CTS_DLY = 15;

   logic            sys_clk = 1'b0;
   logic            sys_reset;
   logic [3:0]      cmd;
   logic [DW-1:0]   data_i;
   logic [NG-1:0]   group_en;
   logic            cts;
   logic            error_flag;
   logic [DW-1:0]   data_loop_o;
   logic [NG*NC-1:0] pwm_o;
   logic            update_pending;
   logic [15:0]     frame_cnt;

   int checks = 0;
   int errors = 0;

   turn_on_pwm_array dut (
      .sys_clk        (sys_clk),
      .sys_reset      (sys_reset),
      .cmd            (cmd),
      .data_i         (data_i),
      .group_en       (group_en),
      .cts            (cts),
      .error_flag     (error_flag),
      .data_loop_o    (data_loop_o),
      .pwm_o          (pwm_o),
      .update_pending (update_pending),
      .frame_cnt      (frame_cnt)
   );

   always #5 sys_clk = ~sys_clk;

   // Behavioural model: quiet-sample count, phase within the 255-cycle period,
   // and brightness arrays, updated once per rising edge.
   bit             model_valid = 1'b0;
   int             quiet;
   bit             m_strobe;
   int             phase;
   logic [7:0]     m_shadow [NG][NC];
   logic [7:0]     m_active [NG][NC];
   bit             m_pending;
   int             m_frames;
   logic [NG*NC-1:0] m_pwm;
   logic [NG*NC-1:0] np;
   bit             cap;

   always @(posedge sys_clk) begin
      if (sys_reset) begin
         model_valid = 1'b1;
         quiet = 0; m_strobe = 1'b0; phase = 0; m_pending = 1'b0; m_frames = 0; m_pwm = '0;
         for (int g = 0; g < NG; g++)
            for (int c = 0; c < NC; c++) begin
               m_shadow[g][c] = 8'h00;
               m_active[g][c] = 8'h00;
            end
      end else begin
         for (int g = 0; g < NG; g++)
            for (int c = 0; c < NC; c++)
               np[g*NC+c] = (m_active[g][c] > phase) && group_en[g] && (cmd != 4'b1101);
         cap = m_strobe && (cmd != 4'b1110) && !error_flag;
         if (phase == 254 && m_pending) begin
            m_active = m_shadow;
            m_frames = (m_frames + 1) % 65536;
            m_pending = 1'b0;
         end
         if (cap) begin
            for (int g = 0; g < NG; g++)
               if (group_en[g])
                  for (int c = 0; c < NC; c++)
                     m_shadow[g][c] = data_i[(g*NC+c)*8 +: 8];
            m_pending = 1'b1;
         end
         if (cts) quiet = 0;
         else if (quiet <= CTS_DLY) quiet = quiet + 1;
         m_strobe = (quiet == CTS_DLY);
         phase = (phase + 1) % 255;
         m_pwm = np;
      end
   end

   function automatic logic [DW-1:0] model_loop();
      logic [DW-1:0] v;
      for (int g = 0; g < NG; g++)
         for (int c = 0; c < NC; c++)
            v[(g*NC+c)*8 +: 8] = m_active[g][c];
      return v;
   endfunction

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge sys_clk) begin
      if (model_valid) begin
         chk("model_loop", data_loop_o, model_loop());
         chk("model_pwm", DW'(pwm_o), DW'(m_pwm));
         chk("model_pending", DW'(update_pending), DW'(m_pending));
         chk("model_frame", DW'(frame_cnt), DW'(m_frames));
      end
   end

   function automatic logic [DW-1:0] fill(input logic [7:0] v);
      return {(NG*NC){v}};
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge sys_clk);
   endtask

   task automatic strobe();
      cts = 1'b1;
      tick(1);
      cts = 1'b0;
      tick(CTS_DLY + 1);
   endtask

   task automatic wait_frame(input int target);
      int n = 0;
      while (frame_cnt != 16'(target) && n < 600) begin
         tick(1);
         n++;
      end
      chk("wait_frame", DW'(frame_cnt), DW'(target));
   endtask

   task automatic wait_phase(input int target);
      int n = 0;
      tick(1);
      while (phase != target && n < 300) begin
         tick(1);
         n++;
      end
      chk("wait_phase", DW'(phase), DW'(target));
   endtask

   logic [DW-1:0] duty_data;
   logic [DW-1:0] exp_v;
   int cnt0, cnt1, cnt2;
   int f0;

   initial begin
      sys_reset = 1'b1; cmd = 4'h0; data_i = '0; group_en = 4'hF;
      cts = 1'b1; error_flag = 1'b0;
      tick(2);
      chk("reset_loop", data_loop_o, '0);
      chk("reset_pwm", DW'(pwm_o), '0);
      chk("reset_pending", DW'(update_pending), '0);
      chk("reset_frame", DW'(frame_cnt), '0);
      sys_reset = 1'b0;

      // CTS restart: six quiet samples, one busy sample, then 15 quiet samples.
      duty_data = fill(8'h20);
      duty_data[7:0] = 8'd64;
      duty_data[15:8] = 8'd0;
      duty_data[23:16] = 8'd255;
      data_i = duty_data;
      cts = 1'b0;
      tick(6);
      cts = 1'b1;
      tick(1);
      cts = 1'b0;
      tick(CTS_DLY);
      chk("cts_no_early_capture", DW'(update_pending), DW'(1'b0));
      tick(1);
      chk("cts_capture", DW'(update_pending), DW'(1'b1));
      chk("cts_no_commit_yet", DW'(frame_cnt), DW'(0));

      // Duty accuracy over one full period.
      wait_frame(1);
      chk("duty_loop", data_loop_o, duty_data);
      cnt0 = 0; cnt1 = 0; cnt2 = 0;
      for (int i = 0; i < 255; i++) begin
         tick(1);
         cnt0 += int'(pwm_o[0]);
         cnt1 += int'(pwm_o[1]);
         cnt2 += int'(pwm_o[2]);
      end
      chk("duty_64", DW'(cnt0), DW'(64));
      chk("duty_0", DW'(cnt1), DW'(0));
      chk("duty_255", DW'(cnt2), DW'(255));

      // HOLD and error_flag suppress capture.
      data_i = fill(8'h80);
      strobe();
      wait_frame(2);
      chk("hold_base", data_loop_o, fill(8'h80));
      cmd = 4'b1110;
      data_i = fill(8'h10);
      strobe();
      tick(300);
      chk("hold_loop", data_loop_o, fill(8'h80));
      chk("hold_frame", DW'(frame_cnt), DW'(2));
      cmd = 4'h0;
      error_flag = 1'b1;
      strobe();
      tick(300);
      chk("err_loop", data_loop_o, fill(8'h80));
      chk("err_frame", DW'(frame_cnt), DW'(2));
      error_flag = 1'b0;

      // Capture lands exactly on the wrap edge.
      f0 = int'(frame_cnt);
      cts = 1'b1;
      data_i = fill(8'h33);
      wait_phase(185);
      cts = 1'b0;
      wait_phase(210);
      cts = 1'b1;
      data_i = fill(8'h66);
      wait_phase(239);
      cts = 1'b0;
      wait_phase(0);
      chk("bnd_old_commit", data_loop_o, fill(8'h33));
      chk("bnd_pending", DW'(update_pending), DW'(1'b1));
      chk("bnd_frame1", DW'(frame_cnt), DW'(f0 + 1));
      wait_phase(0);
      chk("bnd_new_commit", data_loop_o, fill(8'h66));
      chk("bnd_pending_clr", DW'(update_pending), DW'(1'b0));
      chk("bnd_frame2", DW'(frame_cnt), DW'(f0 + 2));

      // BLANK and per-group enable.
      wait_phase(10);
      cmd = 4'b1101;
      tick(1);
      chk("blank_pwm", DW'(pwm_o), '0);
      chk("blank_loop", data_loop_o, fill(8'h66));
      cmd = 4'h0;
      group_en = 4'b1011;
      tick(1);
      chk("en_pwm_nonzero", DW'(pwm_o != '0), DW'(1'b1));
      chk("en_grp2_off", DW'(pwm_o[17:12]), '0);
      data_i = fill(8'h22);
      strobe();
      wait_frame(f0 + 3);
      exp_v = fill(8'h22);
      exp_v[2*48 +: 48] = {6{8'h66}};
      chk("en_grp2_kept", data_loop_o, exp_v);
      group_en = 4'hF;

      // Reset discards a pending update.
      data_i = fill(8'h55);
      strobe();
      chk("rst_pre_pending", DW'(update_pending), DW'(1'b1));
      cts = 1'b1;
      sys_reset = 1'b1;
      tick(1);
      chk("rst_loop", data_loop_o, '0);
      chk("rst_pwm", DW'(pwm_o), '0);
      chk("rst_frame", DW'(frame_cnt), '0);
      chk("rst_pending", DW'(update_pending), '0);
      sys_reset = 1'b0;
      tick(300);
      chk("rst_never_commit", data_loop_o, '0);
      chk("rst_frame_after", DW'(frame_cnt), '0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
